// File: rtl/ps2_scancode_rx_if.sv
// PS/2 pin and scan-code output bundle for ps2_scancode_rx.
// slave: the receiver; master: whatever drives the pins and consumes codes.
interface ps2_scancode_rx_if;
  logic       PS2_CLK;
  logic       PS2_DATA;
  logic [7:0] CODEWORD;
  logic       TRIG_ARR;
  logic       BREAK;
  logic       EXTENDED;
  logic       FRAME_ERR;

  modport slave (
    input  PS2_CLK, PS2_DATA,
    output CODEWORD, TRIG_ARR, BREAK, EXTENDED, FRAME_ERR
  );

  modport master (
    output PS2_CLK, PS2_DATA,
    input  CODEWORD, TRIG_ARR, BREAK, EXTENDED, FRAME_ERR
  );
endinterface

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host frame receiver; strips F0/E0 prefixes and strobes make codes.
// Optional macro PS2_PARITY_CHECK_EN enables odd-parity rejection of frames.
module ps2_scancode_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 16
) (
  input  logic                CLK,
  input  logic                RST_N,
  ps2_scancode_rx_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TMO_ONE   = CNT_W'(1);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall_s;
  logic                   timeout_s;
  logic                   parity_ok_s;

  state_e                 state_q, state_d;
  logic [7:0]             shift_q, shift_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]       tmo_q, tmo_d;
  logic                   brk_pend_q, brk_pend_d;
  logic                   ext_pend_q, ext_pend_d;
  logic [7:0]             codeword_q, codeword_d;
  logic                   break_q, break_d;
  logic                   ext_q, ext_d;
  logic                   trig_q, trig_d;
  logic                   ferr_q, ferr_d;

  // Pin synchronisers plus one extra PS2_CLK stage for edge detection.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      clk_sync_q  <= {SYNC_STAGES{1'b1}};
      data_sync_q <= {SYNC_STAGES{1'b1}};
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], bus.PS2_CLK};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], bus.PS2_DATA};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign clk_s     = clk_sync_q[SYNC_STAGES-1];
  assign data_s    = data_sync_q[SYNC_STAGES-1];
  assign fall_s    = clk_prev_q & ~clk_s;
  assign timeout_s = (tmo_q >= TMO_LIMIT);

`ifdef PS2_PARITY_CHECK_EN
  logic par_q;

  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  // Parity bit capture, used only by the optional check in STOP.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      par_q <= 1'b0;
    end else if ((state_q == PARITY) && fall_s) begin
      par_q <= data_s;
    end else begin
      par_q <= par_q;
    end
  end

  assign parity_ok_s = odd_parity_ok(shift_q, par_q);
`else
  assign parity_ok_s = 1'b1;
`endif

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      shift_q    <= 8'h00;
      bit_cnt_q  <= 3'd0;
      tmo_q      <= '0;
      brk_pend_q <= 1'b0;
      ext_pend_q <= 1'b0;
      codeword_q <= 8'h00;
      break_q    <= 1'b0;
      ext_q      <= 1'b0;
      trig_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      tmo_q      <= tmo_d;
      brk_pend_q <= brk_pend_d;
      ext_pend_q <= ext_pend_d;
      codeword_q <= codeword_d;
      break_q    <= break_d;
      ext_q      <= ext_d;
      trig_q     <= trig_d;
      ferr_q     <= ferr_d;
    end
  end

  // Frame FSM, timeout counter and prefix handling.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    tmo_d      = tmo_q;
    brk_pend_d = brk_pend_q;
    ext_pend_d = ext_pend_q;
    codeword_d = codeword_q;
    break_d    = break_q;
    ext_d      = ext_q;
    trig_d     = 1'b0;
    ferr_d     = 1'b0;

    if ((state_q == IDLE) || (state_q == DONE) || fall_s) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TMO_ONE;
    end

    case (state_q)
      IDLE: begin
        if (fall_s && !data_s) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (fall_s) begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end else begin
            state_d = DATA;
          end
        end else if (timeout_s) begin
          ferr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (fall_s) begin
          state_d = STOP;
        end else if (timeout_s) begin
          ferr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        if (fall_s) begin
          if (data_s && parity_ok_s) begin
            state_d = DONE;
          end else begin
            ferr_d  = 1'b1;
            state_d = IDLE;
          end
        end else if (timeout_s) begin
          ferr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = STOP;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (shift_q == 8'hF0) begin
          brk_pend_d = 1'b1;
        end else if (shift_q == 8'hE0) begin
          ext_pend_d = 1'b1;
        end else begin
          // Break codes update the outputs silently so only presses strobe.
          codeword_d = shift_q;
          break_d    = brk_pend_q;
          ext_d      = ext_pend_q;
          trig_d     = ~brk_pend_q;
          brk_pend_d = 1'b0;
          ext_pend_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.CODEWORD  = codeword_q;
  assign bus.TRIG_ARR  = trig_q;
  assign bus.BREAK     = break_q;
  assign bus.EXTENDED  = ext_q;
  assign bus.FRAME_ERR = ferr_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: bit-banged PS/2 frames with hand-computed results.
// Reduced TIMEOUT_CYCLES keeps the timeout scenarios short.
module tb_ps2_scancode_rx;
  localparam int TMO = 1000;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   trig_cnt = 0;
  int   ferr_cnt = 0;
  int   pulse_viol = 0;
  logic trig_prev = 1'b0;
  logic ferr_prev = 1'b0;
  int   t0;
  int   f0;

  always #5 CLK = ~CLK;

  ps2_scancode_rx_if bus();

  ps2_scancode_rx #(
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(TMO),
    .CNT_W         (16)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  // Pulse counters and a guard that no strobe lasts two cycles.
  always @(posedge CLK) begin
    #1;
    if (bus.TRIG_ARR) trig_cnt++;
    if (bus.FRAME_ERR) ferr_cnt++;
    if ((bus.TRIG_ARR && trig_prev) || (bus.FRAME_ERR && ferr_prev)) pulse_viol++;
    trig_prev = bus.TRIG_ARR;
    ferr_prev = bus.FRAME_ERR;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic par_flip,
                                          input logic stop);
    return {stop, (~^b) ^ par_flip, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      bus.PS2_DATA = f[i];
      repeat (5) @(negedge CLK);
      bus.PS2_CLK = 1'b0;
      repeat (10) @(negedge CLK);
      bus.PS2_CLK = 1'b1;
      repeat (5) @(negedge CLK);
    end
    bus.PS2_DATA = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_bits(mk_frame(b, 1'b0, 1'b1), 11);
    repeat (5) @(negedge CLK);
  endtask

  initial begin
    bus.PS2_CLK  = 1'b1;
    bus.PS2_DATA = 1'b1;
    RST_N        = 1'b0;
    repeat (5) @(negedge CLK);
    check("rst_codeword", {24'd0, bus.CODEWORD}, 32'h0);
    check("rst_trig", {31'd0, bus.TRIG_ARR}, 32'h0);
    check("rst_break", {31'd0, bus.BREAK}, 32'h0);
    check("rst_ext", {31'd0, bus.EXTENDED}, 32'h0);
    check("rst_ferr", {31'd0, bus.FRAME_ERR}, 32'h0);
    RST_N = 1'b1;
    repeat (5) @(negedge CLK);

    // Partial 0x1C frame killed by reset: nothing emitted, no later timeout.
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 5);
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (TMO + 20) @(negedge CLK);
    check("midrst_trig_cnt", trig_cnt, 0);
    check("midrst_ferr_cnt", ferr_cnt, 0);
    check("midrst_codeword", {24'd0, bus.CODEWORD}, 32'h0);

    // Full 0x1C frame with latency measured from the driven stop-bit edge.
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 10);
    bus.PS2_DATA = 1'b1;
    repeat (5) @(negedge CLK);
    bus.PS2_CLK = 1'b0;
    repeat (3) @(negedge CLK);
    check("lat_early", {31'd0, bus.TRIG_ARR}, 32'h0);
    @(negedge CLK);
    check("lat_hit", {31'd0, bus.TRIG_ARR}, 32'h1);
    check("lat_codeword", {24'd0, bus.CODEWORD}, 32'h1C);
    @(negedge CLK);
    check("lat_late", {31'd0, bus.TRIG_ARR}, 32'h0);
    repeat (7) @(negedge CLK);
    bus.PS2_CLK = 1'b1;
    repeat (10) @(negedge CLK);
    check("first_trig_cnt", trig_cnt, 1);

    // Make then break of the same key.
    t0 = trig_cnt;
    send_frame(8'h1C);
    send_frame(8'hF0);
    send_frame(8'h1C);
    check("mb_trig", trig_cnt - t0, 1);
    check("mb_codeword", {24'd0, bus.CODEWORD}, 32'h1C);
    check("mb_break", {31'd0, bus.BREAK}, 32'h1);
    check("mb_ext", {31'd0, bus.EXTENDED}, 32'h0);

    // Extended make, then extended break.
    t0 = trig_cnt;
    send_frame(8'hE0);
    send_frame(8'h75);
    check("ext_trig", trig_cnt - t0, 1);
    check("ext_codeword", {24'd0, bus.CODEWORD}, 32'h75);
    check("ext_ext", {31'd0, bus.EXTENDED}, 32'h1);
    check("ext_break", {31'd0, bus.BREAK}, 32'h0);
    t0 = trig_cnt;
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h75);
    check("extbrk_trig", trig_cnt - t0, 0);
    check("extbrk_break", {31'd0, bus.BREAK}, 32'h1);
    check("extbrk_ext", {31'd0, bus.EXTENDED}, 32'h1);

    // False start in IDLE is silently ignored.
    f0 = ferr_cnt;
    send_bits(11'h7FF, 1);
    repeat (10) @(negedge CLK);
    check("false_start_ferr", ferr_cnt - f0, 0);

    // Stop-bit error.
    t0 = trig_cnt;
    f0 = ferr_cnt;
    send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 11);
    repeat (5) @(negedge CLK);
    check("stop_ferr", ferr_cnt - f0, 1);
    check("stop_trig", trig_cnt - t0, 0);
    check("stop_codeword", {24'd0, bus.CODEWORD}, 32'h75);

    // Timeout mid-frame keeps a pending break prefix.
    send_frame(8'hF0);
    t0 = trig_cnt;
    f0 = ferr_cnt;
    send_bits(mk_frame(8'h55, 1'b0, 1'b1), 5);
    repeat (TMO + 10) @(negedge CLK);
    check("tmo_ferr", ferr_cnt - f0, 1);
    send_frame(8'h29);
    check("tmo_brk_trig", trig_cnt - t0, 0);
    check("tmo_brk_codeword", {24'd0, bus.CODEWORD}, 32'h29);
    check("tmo_brk_break", {31'd0, bus.BREAK}, 32'h1);
    t0 = trig_cnt;
    send_frame(8'h29);
    send_frame(8'h29);
    check("typematic_trig", trig_cnt - t0, 2);
    check("typematic_break", {31'd0, bus.BREAK}, 32'h0);
    check("typematic_codeword", {24'd0, bus.CODEWORD}, 32'h29);

    // 0x1C with its parity bit inverted.
    t0 = trig_cnt;
    f0 = ferr_cnt;
    send_bits(mk_frame(8'h1C, 1'b1, 1'b1), 11);
    repeat (5) @(negedge CLK);
`ifdef PS2_PARITY_CHECK_EN
    check("par_ferr", ferr_cnt - f0, 1);
    check("par_trig", trig_cnt - t0, 0);
    check("par_codeword", {24'd0, bus.CODEWORD}, 32'h29);
`else
    check("par_ferr", ferr_cnt - f0, 0);
    check("par_trig", trig_cnt - t0, 1);
    check("par_codeword", {24'd0, bus.CODEWORD}, 32'h1C);
`endif

    check("pulse_width", pulse_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
